// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit with a 32-step shift-add multiplier and restoring divider.
// Build option MULDIV_FAST_MUL_EN: MULT/MULTU complete in a single cycle at the issue edge.
module muldiv_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Valid,
    input  logic [31:0] Ins,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] Result
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_wk_hi, r_wk_lo, r_opnd;
    logic        r_is_div, r_neg_res, r_neg_rem;

    logic [5:0]  w_funct;
    logic        w_special, w_is_mul, w_is_div, w_is_mthi, w_is_mtlo, w_is_mfhi, w_is_mflo, w_md_op;
    logic        w_signed, w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;
    logic        w_unused_ins;

    assign w_funct      = Ins[5:0];
    assign w_special    = (Ins[31:26] == 6'd0);
    assign w_is_mul     = w_special && (w_funct == F_MULT || w_funct == F_MULTU);
    assign w_is_div     = w_special && (w_funct == F_DIV  || w_funct == F_DIVU);
    assign w_is_mthi    = w_special && (w_funct == F_MTHI);
    assign w_is_mtlo    = w_special && (w_funct == F_MTLO);
    assign w_is_mfhi    = w_special && (w_funct == F_MFHI);
    assign w_is_mflo    = w_special && (w_funct == F_MFLO);
    assign w_md_op      = w_is_mul || w_is_div || w_is_mthi || w_is_mtlo || w_is_mfhi || w_is_mflo;
    assign w_unused_ins = ^Ins[25:6];

    // Even funct codes (MULT, DIV) are the signed variants.
    assign w_signed = ~w_funct[0];
    assign w_a_neg  = w_signed & A[31];
    assign w_b_neg  = w_signed & B[31];
    assign w_a_mag  = w_a_neg ? -A : A;
    assign w_b_mag  = w_b_neg ? -B : B;

    // One iteration step on magnitudes; signs are restored in FIX.
    logic [32:0] w_sum, w_shift;
    logic        w_ge;
    logic [31:0] w_diff;

    assign w_sum   = {1'b0, r_wk_hi} + (r_wk_lo[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_shift = {r_wk_hi, r_wk_lo[31]};
    assign w_ge    = (w_shift >= {1'b0, r_opnd});
    assign w_diff  = w_shift[31:0] - r_opnd;

    logic [63:0] w_prod_mag, w_prod;
    logic [31:0] w_quot, w_rem, w_fix_hi, w_fix_lo;

    assign w_prod_mag = {r_wk_hi, r_wk_lo};
    assign w_prod     = r_neg_res ? -w_prod_mag : w_prod_mag;
    // A zero divisor leaves |A| as remainder, so sign restore reproduces A exactly.
    assign w_quot     = (r_opnd == 32'd0) ? 32'hFFFF_FFFF : (r_neg_res ? -r_wk_lo : r_wk_lo);
    assign w_rem      = r_neg_rem ? -r_wk_hi : r_wk_hi;
    assign w_fix_hi   = r_is_div ? w_rem  : w_prod[63:32];
    assign w_fix_lo   = r_is_div ? w_quot : w_prod[31:0];

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_mag, w_fast_prod;
    assign w_fast_mag  = {32'd0, w_a_mag} * {32'd0, w_b_mag};
    assign w_fast_prod = (w_a_neg ^ w_b_neg) ? -w_fast_mag : w_fast_mag;
`endif

    assign Busy  = (r_state != S_IDLE);
    assign Stall = Busy & Valid & w_md_op;

    // NOTE: default first so every path assigns Result and no latch is inferred.
    always_comb begin
        Result = 32'd0;
        if (!Busy) begin
            if (w_is_mfhi)      Result = r_hi;
            else if (w_is_mflo) Result = r_lo;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_wk_hi   <= '0;
            r_wk_lo   <= '0;
            r_opnd    <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Valid && (w_is_mul || w_is_div)) begin
`ifdef MULDIV_FAST_MUL_EN
                        if (w_is_mul) begin
                            r_hi <= w_fast_prod[63:32];
                            r_lo <= w_fast_prod[31:0];
                        end else begin
                            r_state <= S_RUN;
                        end
`else
                        r_state <= S_RUN;
`endif
                        r_cnt     <= '0;
                        r_is_div  <= w_is_div;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
                        r_wk_lo   <= w_is_div ? w_a_mag : w_b_mag;
                        r_wk_hi   <= '0;
                    end else if (Valid && w_is_mthi) begin
                        r_hi <= A;
                    end else if (Valid && w_is_mtlo) begin
                        r_lo <= A;
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_wk_hi <= w_ge ? w_diff : w_shift[31:0];
                        r_wk_lo <= {r_wk_lo[30:0], w_ge};
                    end else begin
                        r_wk_hi <= w_sum[32:1];
                        r_wk_lo <= {w_sum[0], r_wk_lo[31:1]};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == LAST_STEP) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand sequences for stall, reset abort and MTHI/MTLO.
// Expected busy lengths for multiplies follow MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
    logic        CLK = 1'b0;
    logic        RST;
    logic        Valid;
    logic [31:0] Ins, A, B;
    logic        Busy, Stall;
    logic [31:0] Result;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_BUSY = 33;

    muldiv_unit #(.DIV_CYCLES(32)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Valid (Valid),
        .Ins   (Ins),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Stall (Stall),
        .Result(Result)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    // Counts cycles with Busy high, bounded so a stuck DUT still ends the run.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (Busy !== 1'b0 && cycles < 100) begin
            @(negedge CLK);
            #1;
            cycles++;
        end
    endtask

    task automatic read_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        Valid = 1'b1;
        Ins = enc(F_MFHI);
        #1 check({name, " MFHI"}, Result, hi);
        Ins = enc(F_MFLO);
        #1 check({name, " MFLO"}, Result, lo);
        Valid = 1'b0;
        Ins = 32'd0;
    endtask

    // Caller is positioned at a negedge; the op issues on the following posedge.
    task automatic run_op(input vec_t v);
        int cyc;
        Valid = 1'b1;
        Ins   = enc(v.funct);
        A     = v.a;
        B     = v.b;
        @(negedge CLK);
        Valid = 1'b0;
        Ins   = 32'd0;
        #1;
        wait_idle(cyc);
        check({v.name, " busy cycles"}, 32'(cyc), 32'(v.busy));
        read_hilo(v.name, v.hi, v.lo);
    endtask

    initial begin
        int cyc;
        int good;

        vecs[0]  = '{"multu max",    F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_BUSY};
        vecs[1]  = '{"mult -1*2",    F_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_BUSY};
        vecs[2]  = '{"mult 3*5",     F_MULT,  32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, MUL_BUSY};
        vecs[3]  = '{"mult min*min", F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_BUSY};
        vecs[4]  = '{"multu msb*2",  F_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, MUL_BUSY};
        vecs[5]  = '{"div -7/2",     F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_BUSY};
        vecs[6]  = '{"divu big/2",   F_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, DIV_BUSY};
        vecs[7]  = '{"divu by 0",    F_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, DIV_BUSY};
        vecs[8]  = '{"div min/-1",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_BUSY};
        vecs[9]  = '{"div 7/-2",     F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_BUSY};
        vecs[10] = '{"div -8/0",     F_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, DIV_BUSY};
        vecs[11] = '{"divu 100/7",   F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_BUSY};
        vecs[12] = '{"divu hex/16",  F_DIVU,  32'h1234_5678, 32'h0000_0010, 32'h0000_0008, 32'h0123_4567, DIV_BUSY};

        // Reset with an MD-op presented: nothing may move.
        RST = 1'b0; Valid = 1'b1; Ins = enc(F_MULT); A = 32'd9; B = 32'd9;
        repeat (3) @(negedge CLK);
        #1;
        check("reset Busy",  {31'd0, Busy},  32'd0);
        check("reset Stall", {31'd0, Stall}, 32'd0);
        read_hilo("reset", 32'd0, 32'd0);
        RST = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            run_op(vecs[i]);
        end

        // MFLO presented right after MULT: stalled with Result 0 for the busy window.
        @(negedge CLK);
        Valid = 1'b1; Ins = enc(F_MULT); A = 32'd7; B = 32'd6;
        @(negedge CLK);
        Ins = enc(F_MFLO);
        #1;
        cyc = 0; good = 0;
        while (Busy !== 1'b0 && cyc < 100) begin
            if (Stall === 1'b1 && Result === 32'd0) good++;
            @(negedge CLK);
            #1;
            cyc++;
        end
        check("mflo-after-mult busy cycles",  32'(cyc),  32'(MUL_BUSY));
        check("mflo-after-mult stalled zero", 32'(good), 32'(MUL_BUSY));
        check("mflo-after-mult Stall end", {31'd0, Stall}, 32'd0);
        check("mflo-after-mult Result", Result, 32'd42);
        Valid = 1'b0; Ins = 32'd0;

        // MTHI held during a DIVU must wait and leave the divide result intact.
        @(negedge CLK);
        Valid = 1'b1; Ins = enc(F_DIVU); A = 32'd100; B = 32'd7;
        @(negedge CLK);
        Ins = enc(F_MTHI); A = 32'h0000_0055;
        #1;
        cyc = 0; good = 0;
        while (Busy !== 1'b0 && cyc < 100) begin
            if (Stall === 1'b1) good++;
            @(negedge CLK);
            #1;
            cyc++;
        end
        check("held mthi stall cycles", 32'(good), 32'(DIV_BUSY));
        @(negedge CLK);
        Valid = 1'b0; Ins = 32'd0;
        #1;
        check("held mthi Busy", {31'd0, Busy}, 32'd0);
        read_hilo("held mthi", 32'h0000_0055, 32'd14);

        // Reset at RUN cycle 10 of a DIV aborts without writing HI/LO.
        @(negedge CLK);
        Valid = 1'b1; Ins = enc(F_DIV); A = 32'hFFFF_FFF9; B = 32'd2;
        repeat (10) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("abort Busy",  {31'd0, Busy},  32'd0);
        check("abort Stall", {31'd0, Stall}, 32'd0);
        read_hilo("abort", 32'd0, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        run_op('{"post-reset mult", F_MULT, 32'd3, 32'd5, 32'd0, 32'd15, MUL_BUSY});

        // MTHI/MTLO complete with no Busy; Valid=0 or non-MD encodings change nothing.
        @(negedge CLK);
        Valid = 1'b1; Ins = enc(F_MTHI); A = 32'hCAFE_BABE;
        #1 check("mthi Busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        Ins = enc(F_MTLO); A = 32'h1357_9BDF;
        #1 check("mtlo Busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        Valid = 1'b0; Ins = enc(F_MTHI); A = 32'hDEAD_0001;
        @(negedge CLK);
        Valid = 1'b1; Ins = {6'd1, 20'd0, F_MTLO}; A = 32'hDEAD_0002;
        @(negedge CLK);
        Valid = 1'b1; Ins = {6'd1, 20'd0, F_MULT}; A = 32'd2; B = 32'd2;
        @(negedge CLK);
        #1 check("non-MD mult Busy", {31'd0, Busy}, 32'd0);
        read_hilo("mthi/mtlo", 32'hCAFE_BABE, 32'h1357_9BDF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
